// File: rtl/spart_echo_buffered_pkg.sv
// spart_pkg
//   Shared definitions for the buffered SPART echo controller:
//   - state_e      : controller states (divisor programming, idle, data read, data write)
//   - ADDR_*       : SPART register addresses driven on ioaddr
//   - baud_divisor : 16-bit divisor floor(clk_hz / (16 * baud)) for a baud select code
//   - to_upper     : ASCII lower-case letter to upper-case, other bytes unchanged
package spart_pkg;

  typedef enum logic [2:0] {
    ST_INIT_LO = 3'd0,
    ST_INIT_HI = 3'd1,
    ST_IDLE    = 3'd2,
    ST_RD      = 3'd3,
    ST_WR      = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  // br_cfg: 00=4800, 01=9600, 10=19200, 11=38400 baud
  function automatic logic [15:0] baud_divisor(input int unsigned clk_hz,
                                               input logic [1:0]   br_cfg);
    int unsigned baud;
    case (br_cfg)
      2'b00:   baud = 32'd4800;
      2'b01:   baud = 32'd9600;
      2'b10:   baud = 32'd19200;
      2'b11:   baud = 32'd38400;
      default: baud = 32'd9600;
    endcase
    baud_divisor = 16'(clk_hz / (32'd16 * baud));
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if ((b >= 8'h61) && (b <= 8'h7a)) begin
      to_upper = b - 8'h20;
    end else begin
      to_upper = b;
    end
  endfunction

endpackage

// File: rtl/spart_echo_buffered_if.sv
// spart_echo_buffered_if
//   Control/handshake signals between the echo controller and the SPART.
//   rda    : SPART receive data available
//   tbr    : SPART transmit buffer ready
//   iocs   : SPART chip select
//   iorw   : 1 = read, 0 = write
//   ioaddr : SPART register address
//   The 8-bit data bus is a resolved tri-state net and is carried as a
//   separate inout port of the controller.
interface spart_echo_buffered_if;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  modport master (
    input  rda,
    input  tbr,
    output iocs,
    output iorw,
    output ioaddr
  );

  modport slave (
    output rda,
    output tbr,
    input  iocs,
    input  iorw,
    input  ioaddr
  );
endinterface

// File: rtl/spart_echo_buffered_fifo.sv
// sync_fifo
//   Single-clock FIFO with synchronous active-low reset.
//   Ports: clk, rst_n, push/din (write, ignored when full),
//   pop (read, ignored when empty), dout (head, combinational),
//   full, empty, level (entries held, updates the cycle after push/pop).
//   DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (level_r == (AW+1)'(DEPTH));
  assign empty = (level_r == (AW+1)'(0));
  assign level = level_r;
  assign dout  = mem_r[rd_ptr_r];

  // Qualify requests so a full FIFO never overwrites and an empty one never underflows
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // Storage array; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (do_push_s && !do_pop_s) begin
        level_r <= level_r + (AW+1)'(1);
      end else if (do_pop_s && !do_push_s) begin
        level_r <= level_r - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/spart_echo_buffered.sv
// spart_echo_buffered
//   Programs the SPART baud divisor, then echoes every received byte back
//   through a receive FIFO, optionally converting ASCII a..z to A..Z.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     br_cfg      : baud select (a change triggers divisor reprogramming)
//     upcase      : 1 = upper-case letters on transmit, 0 = raw echo
//     bus         : SPART control interface (rda, tbr, iocs, iorw, ioaddr)
//     databus     : bidirectional SPART data bus
//     fifo_level  : bytes currently buffered
//     overflow    : sticky, a received byte was dropped because the FIFO was full
module spart_echo_buffered
  import spart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  br_cfg,
  input  logic                        upcase,
  spart_echo_buffered_if.master       bus,
  inout  wire  [7:0]                  databus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  state_e      state_r;
  state_e      state_s;
  logic [1:0]  br_cfg_r;
  logic        overflow_r;

  logic [15:0] divisor_s;
  logic        push_s;
  logic        pop_s;
  logic        ovf_set_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [7:0]  fifo_head_s;

  logic        iocs_s;
  logic        iorw_s;
  logic [1:0]  ioaddr_s;
  logic        drive_en_s;
  logic [7:0]  drive_val_s;

  // Divisor follows the live baud select so a reprogram writes the new rate
  assign divisor_s = baud_divisor(CLK_HZ, br_cfg);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (databus),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Next-state and FIFO strobes; IDLE priority is reprogram, then read, then write
  always_comb begin
    state_s   = state_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    case (state_r)
      ST_INIT_LO: begin
        state_s = ST_INIT_HI;
      end
      ST_INIT_HI: begin
        state_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (br_cfg != br_cfg_r) begin
          state_s = ST_INIT_LO;
        end else if (bus.rda) begin
          state_s = ST_RD;
        end else if (bus.tbr && !fifo_empty_s) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        state_s = ST_IDLE;
        // The read still happens when full so the SPART clears rda; the byte is dropped
        if (fifo_full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
      ST_WR: begin
        state_s = ST_IDLE;
        pop_s   = 1'b1;
      end
      default: begin
        state_s = ST_INIT_LO;
      end
    endcase
  end

  // State, captured baud select and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_INIT_LO;
      br_cfg_r   <= br_cfg;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_INIT_HI) begin
        br_cfg_r <= br_cfg;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Moore decode of the SPART access for the current state
  always_comb begin
    iocs_s      = 1'b0;
    iorw_s      = 1'b0;
    ioaddr_s    = ADDR_DATA;
    drive_en_s  = 1'b0;
    drive_val_s = 8'h00;
    case (state_r)
      ST_INIT_LO: begin
        iocs_s      = 1'b1;
        ioaddr_s    = ADDR_DIV_LO;
        drive_en_s  = 1'b1;
        drive_val_s = divisor_s[7:0];
      end
      ST_INIT_HI: begin
        iocs_s      = 1'b1;
        ioaddr_s    = ADDR_DIV_HI;
        drive_en_s  = 1'b1;
        drive_val_s = divisor_s[15:8];
      end
      ST_RD: begin
        iocs_s = 1'b1;
        iorw_s = 1'b1;
      end
      ST_WR: begin
        iocs_s      = 1'b1;
        drive_en_s  = 1'b1;
        drive_val_s = upcase ? to_upper(fifo_head_s) : fifo_head_s;
      end
      default: begin
        iocs_s = 1'b0;
      end
    endcase
  end

  // Reset gates every bus output so the SPART sees no access while rst_n is low
  assign bus.iocs   = rst_n & iocs_s;
  assign bus.iorw   = rst_n & iorw_s;
  assign bus.ioaddr = rst_n ? ioaddr_s : ADDR_DATA;
  assign databus    = (rst_n && drive_en_s) ? drive_val_s : 8'hzz;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_spart_echo_buffered.sv
`timescale 1ns/1ps
module tb_spart_echo_buffered;

  localparam int CLK_HZ = 50_000_000;
  localparam int DEPTH  = 8;

  localparam int EV_INIT_LO = 0;
  localparam int EV_INIT_HI = 1;
  localparam int EV_RD      = 2;
  localparam int EV_WR      = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       upcase = 1'b0;
  wire  [7:0] databus;
  logic [3:0] fifo_level;
  logic       overflow;

  logic       force_zero = 1'b1;
  logic [7:0] rx_head = 8'h00;

  spart_echo_buffered_if spart_if ();

  spart_echo_buffered #(
    .CLK_HZ     (CLK_HZ),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_cfg     (br_cfg),
    .upcase     (upcase),
    .bus        (spart_if.master),
    .databus    (databus),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // SPART side of the bus: returns the pending byte on a DATA read
  wire rd_acc = spart_if.iocs & spart_if.iorw & (spart_if.ioaddr == 2'b00);
  assign databus = force_zero ? 8'h00 : (rd_acc ? rx_head : 8'hzz);

  // Reference model state
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic [7:0] rx_pend[$];
  ev_t        ev_log[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic logic [15:0] model_div(input logic [1:0] cfg);
    int baud_tab[4] = '{4800, 9600, 19200, 38400};
    return 16'(CLK_HZ / (16 * baud_tab[cfg]));
  endfunction

  function automatic logic [7:0] model_tx(input logic [7:0] b, input logic up);
    if (up && b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
    return b;
  endfunction

  task automatic update_rx();
    spart_if.rda = (rx_pend.size() != 0);
    rx_head = (rx_pend.size() != 0) ? rx_pend[0] : 8'h00;
  endtask

  // One clock: observe at negedge, update the model, advance to #1 past posedge
  task automatic step();
    bit was_rd;
    logic [15:0] dv;
    logic [7:0]  exp_b;
    was_rd = 1'b0;
    @(negedge clk);
    if (rst_n) begin
      n_checks++;
      if (fifo_level !== 4'(exp_q.size())) begin
        n_fail++;
        $display("FAIL fifo_level cyc %0d: got %0d expected %0d", cyc, fifo_level, exp_q.size());
      end
      n_checks++;
      if (overflow !== exp_ovf) begin
        n_fail++;
        $display("FAIL overflow cyc %0d: got %0b expected %0b", cyc, overflow, exp_ovf);
      end
      if (spart_if.iocs) begin
        dv = model_div(br_cfg);
        if (spart_if.iorw) begin
          if (spart_if.ioaddr == 2'b00) begin
            ev_log.push_back('{kind: EV_RD, data: rx_head, cyc: cyc});
            if (exp_q.size() < DEPTH) exp_q.push_back(rx_head);
            else exp_ovf = 1'b1;
            was_rd = 1'b1;
          end else begin
            n_checks++; n_fail++;
            $display("FAIL read_addr cyc %0d: got %0d expected 0", cyc, spart_if.ioaddr);
          end
        end else begin
          n_checks++;
          case (spart_if.ioaddr)
            2'b10: begin
              ev_log.push_back('{kind: EV_INIT_LO, data: databus, cyc: cyc});
              if (databus !== dv[7:0]) begin
                n_fail++;
                $display("FAIL div_lo cyc %0d: got %02h expected %02h", cyc, databus, dv[7:0]);
              end
            end
            2'b11: begin
              ev_log.push_back('{kind: EV_INIT_HI, data: databus, cyc: cyc});
              if (databus !== dv[15:8]) begin
                n_fail++;
                $display("FAIL div_hi cyc %0d: got %02h expected %02h", cyc, databus, dv[15:8]);
              end
            end
            2'b00: begin
              ev_log.push_back('{kind: EV_WR, data: databus, cyc: cyc});
              if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected cyc %0d: got %02h expected no write", cyc, databus);
              end else begin
                exp_b = model_tx(exp_q.pop_front(), upcase);
                if (databus !== exp_b) begin
                  n_fail++;
                  $display("FAIL tx_byte cyc %0d: got %02h expected %02h", cyc, databus, exp_b);
                end
              end
            end
            default: begin
              n_fail++;
              $display("FAIL write_addr cyc %0d: got %0d expected 0/2/3", cyc, spart_if.ioaddr);
            end
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (was_rd) begin
      void'(rx_pend.pop_front());
      update_rx();
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rx_pend.size() != 0 || (spart_if.tbr && exp_q.size() != 0)) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d cycles expected under %0d", n, budget);
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; force_zero = 1'b1; br_cfg = 2'b01; upcase = 1'b0;
    spart_if.rda = 1'b0; spart_if.tbr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (spart_if.iocs !== 1'b0) begin n_fail++; $display("FAIL rst_iocs: got %0b expected 0", spart_if.iocs); end
    n_checks++; if (spart_if.iorw !== 1'b0) begin n_fail++; $display("FAIL rst_iorw: got %0b expected 0", spart_if.iorw); end
    n_checks++; if (spart_if.ioaddr !== 2'b00) begin n_fail++; $display("FAIL rst_ioaddr: got %0d expected 0", spart_if.ioaddr); end
    n_checks++; if (databus !== 8'h00) begin n_fail++; $display("FAIL rst_bus_released: got %02h expected 00", databus); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1; force_zero = 1'b0;
    exp_q.delete(); exp_ovf = 1'b0; rx_pend.delete(); update_rx();
    @(negedge clk);
    n_checks++; if (spart_if.iocs !== 1'b1 || spart_if.iorw !== 1'b0 || spart_if.ioaddr !== 2'b10 || databus !== 8'h45) begin
      n_fail++; $display("FAIL init_cycle1: got cs%0b rw%0b a%0d %02h expected cs1 rw0 a2 45", spart_if.iocs, spart_if.iorw, spart_if.ioaddr, databus);
    end
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if (spart_if.iocs !== 1'b1 || spart_if.ioaddr !== 2'b11 || databus !== 8'h01) begin
      n_fail++; $display("FAIL init_cycle2: got cs%0b a%0d %02h expected cs1 a3 01", spart_if.iocs, spart_if.ioaddr, databus);
    end
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if (spart_if.iocs !== 1'b0) begin n_fail++; $display("FAIL init_idle: got %0b expected 0", spart_if.iocs); end
    @(posedge clk); #1;
  endtask

  task automatic test_upcase_echo();
    logic [7:0] got[$];
    int rd_cyc, wr_cyc;
    rd_cyc = -100; wr_cyc = -1;
    upcase = 1'b1; spart_if.tbr = 1'b1; ev_log.delete();
    rx_pend.push_back(8'h68); update_rx(); drain(40);
    rx_pend.push_back(8'h69); update_rx(); drain(40);
    foreach (ev_log[i]) begin
      if (ev_log[i].kind == EV_RD && rd_cyc < 0) rd_cyc = ev_log[i].cyc;
      if (ev_log[i].kind == EV_WR) begin
        got.push_back(ev_log[i].data);
        if (wr_cyc < 0) wr_cyc = ev_log[i].cyc;
      end
    end
    n_checks++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL upcase_count: got %0d expected 2", got.size());
    end else begin
      n_checks++; if (got[0] !== 8'h48) begin n_fail++; $display("FAIL upcase_b0: got %02h expected 48", got[0]); end
      n_checks++; if (got[1] !== 8'h49) begin n_fail++; $display("FAIL upcase_b1: got %02h expected 49", got[1]); end
    end
    n_checks++;
    if (wr_cyc - rd_cyc != 2) begin n_fail++; $display("FAIL echo_latency: got %0d expected 2", wr_cyc - rd_cyc); end
  endtask

  task automatic test_priority();
    upcase = 1'b0; spart_if.tbr = 1'b0;
    rx_pend.push_back(8'h31); update_rx(); drain(40);
    ev_log.delete();
    rx_pend.push_back(8'h32); update_rx(); spart_if.tbr = 1'b1;
    drain(40);
    n_checks++;
    if (ev_log.size() < 3) begin
      n_fail++; $display("FAIL prio_events: got %0d expected 3", ev_log.size());
    end else begin
      n_checks++; if (ev_log[0].kind != EV_RD) begin n_fail++; $display("FAIL prio_first: got %0d expected %0d", ev_log[0].kind, EV_RD); end
      n_checks++; if (ev_log[1].kind != EV_WR || ev_log[1].data !== 8'h31) begin
        n_fail++; $display("FAIL prio_second: got k%0d %02h expected k%0d 31", ev_log[1].kind, ev_log[1].data, EV_WR);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] sent[9];
    int n_wr;
    spart_if.tbr = 1'b0; upcase = 1'($urandom_range(0, 1)); ev_log.delete();
    for (int i = 0; i < 9; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      rx_pend.push_back(sent[i]);
    end
    update_rx(); drain(80);
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    ev_log.delete(); spart_if.tbr = 1'b1; drain(80);
    n_wr = 0;
    foreach (ev_log[i]) if (ev_log[i].kind == EV_WR) n_wr++;
    n_checks++; if (n_wr != 8) begin n_fail++; $display("FAIL ovf_tx_count: got %0d expected 8", n_wr); end
    n_checks++;
    if (ev_log.size() == 0 || ev_log[ev_log.size()-1].data !== model_tx(sent[7], upcase)) begin
      n_fail++; $display("FAIL ovf_last_byte: got %0d events expected last %02h", ev_log.size(), model_tx(sent[7], upcase));
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_reprogram();
    spart_if.tbr = 1'b0; upcase = 1'b0;
    for (int i = 0; i < 3; i++) rx_pend.push_back(8'($urandom_range(0, 255)));
    update_rx(); drain(40);
    n_checks++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL reprog_level: got %0d expected 3", fifo_level); end
    ev_log.delete();
    br_cfg = 2'b11; spart_if.tbr = 1'b1;
    drain(60);
    n_checks++;
    if (ev_log.size() != 5) begin
      n_fail++; $display("FAIL reprog_events: got %0d expected 5", ev_log.size());
    end else begin
      n_checks++; if (ev_log[0].kind != EV_INIT_LO || ev_log[0].data !== 8'h51) begin
        n_fail++; $display("FAIL reprog_lo: got k%0d %02h expected k0 51", ev_log[0].kind, ev_log[0].data);
      end
      n_checks++; if (ev_log[1].kind != EV_INIT_HI || ev_log[1].data !== 8'h00) begin
        n_fail++; $display("FAIL reprog_hi: got k%0d %02h expected k1 00", ev_log[1].kind, ev_log[1].data);
      end
      for (int i = 2; i < 5; i++) begin
        n_checks++; if (ev_log[i].kind != EV_WR) begin n_fail++; $display("FAIL reprog_wr%0d: got k%0d expected k3", i, ev_log[i].kind); end
      end
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rx_pend.push_back(8'($urandom_range(0, 255)));
        update_rx();
      end
      spart_if.tbr = 1'($urandom_range(0, 1));
      upcase = 1'($urandom_range(0, 1));
      step();
    end
    spart_if.tbr = 1'b1;
    drain(200);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_wr();
    int n;
    spart_if.tbr = 1'b0;
    rx_pend.push_back(8'h55); rx_pend.push_back(8'h66); update_rx(); drain(40);
    spart_if.tbr = 1'b1;
    n = 0;
    while (!(spart_if.iocs && !spart_if.iorw && spart_if.ioaddr == 2'b00) && n < 10) begin
      step(); n++;
    end
    n_checks++; if (n >= 10) begin n_fail++; $display("FAIL midwr_no_write: got %0d cycles expected under 10", n); end
    rst_n = 1'b0; force_zero = 1'b1;
    @(negedge clk);
    n_checks++; if (spart_if.iocs !== 1'b0 || databus !== 8'h00) begin
      n_fail++; $display("FAIL midwr_gated: got cs%0b %02h expected cs0 00", spart_if.iocs, databus);
    end
    @(posedge clk); #1;
    n_checks++; if (fifo_level !== 4'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midwr_cleared: got lvl%0d ovf%0b expected lvl0 ovf0", fifo_level, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; force_zero = 1'b0; spart_if.tbr = 1'b1;
    exp_q.delete(); exp_ovf = 1'b0;
    @(negedge clk);
    n_checks++; if (spart_if.iocs !== 1'b1 || spart_if.ioaddr !== 2'b10 || databus !== 8'h51) begin
      n_fail++; $display("FAIL midwr_restart: got cs%0b a%0d %02h expected cs1 a2 51", spart_if.iocs, spart_if.ioaddr, databus);
    end
    repeat (8) step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_upcase_echo();
    test_priority();
    test_overflow();
    test_reprogram();
    test_random_stream();
    test_reset_mid_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
